// File: rtl/cport_sched.sv
// cport_sched: arbitrates the Cport register bus between host pass-through and a polled
// 16-bit rx/tx word stream. Optional tx drop timeout enabled by `define CPORT_SCHED_TIMEOUT_EN.
module cport_sched #(
  parameter int unsigned POLL_DIV  = 16,
  parameter logic [3:0]  DATA_ADDR = 4'h0,
  parameter logic [3:0]  STAT_ADDR = 4'h1,
  parameter int unsigned RX_BIT    = 0,
  parameter int unsigned TX_BIT    = 1,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [3:0]  HAddr,
  input  logic [15:0] HDataWr,
  output logic [15:0] HDataRd,
  input  logic        HEn,
  input  logic        HRd,
  input  logic        HWr,
  output logic        HWait,
  output logic [15:0] RxData,
  output logic        RxValid,
  input  logic        RxReady,
  input  logic [15:0] TxData,
  input  logic        TxValid,
  output logic        TxReady,
  output logic        TxErr,
  output logic [3:0]  Addr,
  output logic [15:0] DataWr,
  input  logic [15:0] DataRd,
  output logic        En,
  output logic        Rd,
  output logic        Wr
);

  localparam int unsigned CW = $clog2(POLL_DIV);

  typedef enum logic [1:0] {IDLE, POLL, RXRD, TXWR} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_last_rx;
  logic [15:0]   r_rx_data;
  logic          r_rx_valid;
  logic          w_grant;
  logic          w_rx_ok;
  logic          w_tx_ok;
  logic          w_poll_go;

  assign w_grant   = (r_state == IDLE) && HEn;
  assign w_rx_ok   = DataRd[RX_BIT] && !r_rx_valid;
  assign w_tx_ok   = DataRd[TX_BIT] && TxValid;
  assign w_poll_go = (r_cnt == '0) && !HEn && (!r_rx_valid || TxValid);

  assign HDataRd = DataRd;
  assign HWait   = HEn && (r_state != IDLE);
  assign RxData  = r_rx_data;
  assign RxValid = r_rx_valid;

  // Scheduler FSM, poll divider and rx holding slot
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= IDLE;
      r_cnt      <= CW'(POLL_DIV - 1);
      r_last_rx  <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      if (r_state == RXRD) begin
        r_rx_valid <= 1'b1;
        r_rx_data  <= DataRd;
      end else if (r_rx_valid && RxReady) begin
        r_rx_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_poll_go) r_state <= POLL;
          else if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        POLL: begin
          // when both are ready, alternate away from the last service
          if (w_rx_ok && (!w_tx_ok || !r_last_rx)) begin
            r_state <= RXRD;
          end else if (w_tx_ok) begin
            r_state <= TXWR;
          end else begin
            r_state <= IDLE;
            r_cnt   <= CW'(POLL_DIV - 1);
          end
        end
        RXRD: begin
          r_last_rx <= 1'b1;
          r_state   <= IDLE;
        end
        TXWR: begin
          r_last_rx <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  // Cport bus mux: host pass-through when granted, else scheduler cycle
  always_comb begin
    Addr   = '0;
    DataWr = '0;
    En     = 1'b0;
    Rd     = 1'b0;
    Wr     = 1'b0;
    if (w_grant) begin
      Addr   = HAddr;
      DataWr = HDataWr;
      En     = HEn;
      Rd     = HRd;
      Wr     = HWr;
    end else begin
      case (r_state)
        POLL: begin
          Addr = STAT_ADDR;
          En   = 1'b1;
          Rd   = 1'b1;
        end
        RXRD: begin
          Addr = DATA_ADDR;
          En   = 1'b1;
          Rd   = 1'b1;
        end
        TXWR: begin
          Addr   = DATA_ADDR;
          DataWr = TxData;
          En     = 1'b1;
          Wr     = 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef CPORT_SCHED_TIMEOUT_EN
  localparam int unsigned FW = $clog2(TIMEOUT + 1);

  logic [FW-1:0] r_fail;
  logic          r_tx_err;

  // Counts polls that found no tx space; drops the pending word on reaching TIMEOUT
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fail   <= '0;
      r_tx_err <= 1'b0;
    end else begin
      r_tx_err <= 1'b0;
      if ((r_state == TXWR) || ((r_state == POLL) && !TxValid)) begin
        r_fail <= '0;
      end else if ((r_state == POLL) && !DataRd[TX_BIT]) begin
        if (r_fail == FW'(TIMEOUT - 1)) begin
          r_fail   <= '0;
          r_tx_err <= 1'b1;
        end else begin
          r_fail <= r_fail + FW'(1);
        end
      end
    end
  end

  assign TxReady = (r_state == TXWR) || r_tx_err;
  assign TxErr   = r_tx_err;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT == 0);
  assign TxReady = (r_state == TXWR);
  assign TxErr   = 1'b0;
`endif

endmodule

// File: tb/tb_cport_sched.sv
// tb_cport_sched: directed and randomized checks of cport_sched against a queue-based
// model of upcoming Cport bus operations.
module tb_cport_sched;

  localparam int unsigned PD = 16;
  localparam int unsigned TO = 3;
  localparam int OP_STAT = 1;
  localparam int OP_RD   = 2;
  localparam int OP_WR   = 3;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [3:0]  HAddr;
  logic [15:0] HDataWr;
  logic [15:0] HDataRd;
  logic        HEn, HRd, HWr, HWait;
  logic [15:0] RxData;
  logic        RxValid, RxReady;
  logic [15:0] TxData;
  logic        TxValid, TxReady, TxErr;
  logic [3:0]  Addr;
  logic [15:0] DataWr, DataRd;
  logic        En, Rd, Wr;

  cport_sched #(.POLL_DIV(PD), .TIMEOUT(TO)) dut (
    .Clk(Clk), .Reset(Reset),
    .HAddr(HAddr), .HDataWr(HDataWr), .HDataRd(HDataRd),
    .HEn(HEn), .HRd(HRd), .HWr(HWr), .HWait(HWait),
    .RxData(RxData), .RxValid(RxValid), .RxReady(RxReady),
    .TxData(TxData), .TxValid(TxValid), .TxReady(TxReady), .TxErr(TxErr),
    .Addr(Addr), .DataWr(DataWr), .DataRd(DataRd),
    .En(En), .Rd(Rd), .Wr(Wr)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queue of pending scheduler bus cycles plus stream-side state
  int          m_ops[$];
  int          m_cnt;
  bit          m_last_rx;
  bit          m_rxv;
  logic [15:0] m_rxd;
  bit          m_txerr;
  int          m_fail;

  logic [15:0] stat_val, dat_val;
  bit          e_txready, e_hwait;
  bit          obs_poll, obs_hwait;
  int          svc_q[$];
  int          txerr_seen;

  task automatic model_reset();
    m_ops.delete();
    m_cnt     = PD - 1;
    m_last_rx = 1'b0;
    m_rxv     = 1'b0;
    m_rxd     = '0;
    m_txerr   = 1'b0;
    m_fail    = 0;
    e_txready = 1'b0;
    e_hwait   = 1'b0;
  endtask

  // One clock cycle: called #1 after a rising edge with inputs already set
  task automatic cycle();
    int          op;
    bit          idle, grant, een, erd, ewr, old_rxv, rx_ok, tx_ok, txsp;
    logic [3:0]  ea;
    logic [15:0] ed;
    op   = (m_ops.size() == 0) ? 0 : m_ops[0];
    idle = (op == 0);
    if (op == OP_STAT)    DataRd = stat_val;
    else if (op == OP_RD) DataRd = dat_val;
    else                  DataRd = 16'($urandom);
    #4;
    grant = idle && HEn;
    ea = '0; ed = '0; een = 1'b0; erd = 1'b0; ewr = 1'b0;
    if (grant) begin
      ea = HAddr; ed = HDataWr; een = 1'b1; erd = HRd; ewr = HWr;
    end else if (op == OP_STAT) begin
      ea = 4'h1; een = 1'b1; erd = 1'b1;
    end else if (op == OP_RD) begin
      ea = 4'h0; een = 1'b1; erd = 1'b1;
    end else if (op == OP_WR) begin
      ea = 4'h0; een = 1'b1; ewr = 1'b1; ed = TxData;
    end
    e_hwait   = HEn && !idle;
    e_txready = (op == OP_WR) || m_txerr;
    check("addr",    32'(Addr),    32'(ea));
    check("datawr",  32'(DataWr),  32'(ed));
    check("en",      32'(En),      32'(een));
    check("rd",      32'(Rd),      32'(erd));
    check("wr",      32'(Wr),      32'(ewr));
    check("hwait",   32'(HWait),   32'(e_hwait));
    check("hdatard", 32'(HDataRd), 32'(DataRd));
    check("rxvalid", 32'(RxValid), 32'(m_rxv));
    check("rxdata",  32'(RxData),  32'(m_rxd));
    check("txready", 32'(TxReady), 32'(e_txready));
    check("txerr",   32'(TxErr),   32'(m_txerr));
    obs_poll  = !grant && En && Rd && (Addr == 4'h1);
    obs_hwait = HWait;
    if (!grant && En && (Addr == 4'h0)) svc_q.push_back(Wr ? OP_WR : OP_RD);
    if (TxErr) txerr_seen++;

    old_rxv = m_rxv;
    if (op == OP_RD) begin
      m_rxv = 1'b1;
      m_rxd = DataRd;
    end else if (m_rxv && RxReady) begin
      m_rxv = 1'b0;
    end
    m_txerr = 1'b0;
    if (idle) begin
      if (m_cnt == 0 && !HEn && (!old_rxv || TxValid)) m_ops.push_back(OP_STAT);
      else if (m_cnt > 0) m_cnt--;
    end else begin
      void'(m_ops.pop_front());
      if (op == OP_STAT) begin
        txsp  = DataRd[1];
        rx_ok = DataRd[0] && !old_rxv;
        tx_ok = txsp && TxValid;
        if (rx_ok && tx_ok) m_ops.push_back(m_last_rx ? OP_WR : OP_RD);
        else if (rx_ok)     m_ops.push_back(OP_RD);
        else if (tx_ok)     m_ops.push_back(OP_WR);
        else                m_cnt = PD - 1;
`ifdef CPORT_SCHED_TIMEOUT_EN
        if (!TxValid) m_fail = 0;
        else if (!txsp) begin
          m_fail++;
          if (m_fail == TO) begin
            m_txerr = 1'b1;
            m_fail  = 0;
          end
        end
`endif
      end else if (op == OP_RD) begin
        m_last_rx = 1'b1;
      end else begin
        m_last_rx = 1'b0;
        m_fail    = 0;
      end
    end
    @(posedge Clk);
    #1;
  endtask

  task automatic rand_inputs();
    if (!e_hwait) begin
      HEn     = ($urandom % 4) == 0;
      HAddr   = 4'($urandom);
      HDataWr = 16'($urandom);
      HRd     = 1'($urandom);
      HWr     = !HRd;
    end
    if (!TxValid || e_txready) begin
      TxValid = 1'($urandom);
      TxData  = 16'($urandom);
    end
    RxReady  = ($urandom % 3) != 0;
    stat_val = 16'($urandom);
    dat_val  = 16'($urandom);
  endtask

  initial begin
    int first_poll, hw, n_rd, k;
    bit found;
    Reset = 1'b1; HEn = 1'b0; HAddr = '0; HDataWr = '0; HRd = 1'b0; HWr = 1'b0;
    RxReady = 1'b0; TxValid = 1'b1; TxData = 16'h1234; DataRd = '0;
    stat_val = '0; dat_val = '0; txerr_seen = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check("rst_en",     32'(En),      32'(0));
    check("rst_rd",     32'(Rd),      32'(0));
    check("rst_wr",     32'(Wr),      32'(0));
    check("rst_addr",   32'(Addr),    32'(0));
    check("rst_datawr", 32'(DataWr),  32'(0));
    check("rst_rxv",    32'(RxValid), 32'(0));
    check("rst_rxdata", 32'(RxData),  32'(0));
    check("rst_txrdy",  32'(TxReady), 32'(0));
    check("rst_txerr",  32'(TxErr),   32'(0));
    HEn = 1'b1; HAddr = 4'h5; HRd = 1'b1; DataRd = 16'hA5A5;
    #1;
    check("rst_hwait",   32'(HWait),   32'(0));
    check("rst_hdatard", 32'(HDataRd), 32'hA5A5);
    HEn = 1'b0; HRd = 1'b0; HAddr = '0;
    Reset = 1'b0;

    // First poll timing, then alternating rx/tx service
    stat_val = 16'h0003; dat_val = 16'hBEEF; RxReady = 1'b1;
    first_poll = -1;
    svc_q.delete();
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (obs_poll && first_poll < 0) first_poll = i;
      if (e_txready) TxData = TxData + 16'h1;
    end
    check("first_poll", 32'(first_poll), 32'(PD));
    check("svc_count", 32'(svc_q.size() >= 4), 32'(1));
    for (int i = 0; i < 4; i++) begin
      k = (i < svc_q.size()) ? svc_q[i] : -1;
      check("svc_order", 32'(k), 32'((i % 2 == 0) ? OP_RD : OP_WR));
    end

    // Held rx word blocks further data reads
    stat_val = 16'h0001; RxReady = 1'b0; svc_q.delete(); txerr_seen = 0;
    for (int i = 0; i < 80; i++) begin
      cycle();
      if (e_txready) TxData = TxData + 16'h1;
    end
    n_rd = 0;
    foreach (svc_q[i]) if (svc_q[i] == OP_RD) n_rd++;
    check("rx_hold_reads", 32'(n_rd), 32'(1));
`ifdef CPORT_SCHED_TIMEOUT_EN
    check("txerr_seen", 32'(txerr_seen != 0), 32'(1));
`else
    check("txerr_seen", 32'(txerr_seen), 32'(0));
`endif

    // Host request arriving during a poll waits two cycles
    RxReady = 1'b1; stat_val = 16'h0002; TxValid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (m_ops.size() != 0 && m_ops[0] == OP_STAT) found = 1'b1;
      else cycle();
    end
    check("reach_poll", 32'(found), 32'(1));
    HEn = 1'b1; HRd = 1'b1; HWr = 1'b0; HAddr = 4'h7;
    hw = 0;
    for (int i = 0; i < 8; i++) begin
      cycle();
      if (!obs_hwait) break;
      hw++;
    end
    check("host_wait", 32'(hw), 32'(2));
    HEn = 1'b0; HRd = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      cycle();
    end

    // Reset while busy with a held rx word
    HEn = 1'b0; e_hwait = 1'b0; stat_val = 16'h0003; RxReady = 1'b0; TxValid = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (m_ops.size() != 0 && m_rxv) found = 1'b1;
      else cycle();
    end
    check("reach_busy", 32'(found), 32'(1));
    #2 Reset = 1'b1;
    #1;
    check("midrst_en",  32'(En),      32'(0));
    check("midrst_rxv", 32'(RxValid), 32'(0));
    check("midrst_txr", 32'(TxReady), 32'(0));
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    model_reset();
    for (int i = 0; i < 200; i++) begin
      rand_inputs();
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
